// File: rtl/yasac_runner.sv
// Host-side run controller for one yasac processor: loads arguments, launches a run, waits for ready, captures results.
// Optional YASAC_RUNNER_CHAIN_EN adds a chain input that feeds the previous results back as arguments. Reset input is active-low.
module yasac_runner #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        arg_we,
  input  logic [2:0]  arg_sel,
  input  logic [7:0]  arg_data,
`ifdef YASAC_RUNNER_CHAIN_EN
  input  logic        chain,
`endif
  input  logic [2:0]  res_sel,
  output logic [7:0]  res_data,
  output logic        p_start,
  input  logic        p_ready,
  input  logic [7:0]  p_out00,
  input  logic [7:0]  p_out01,
  input  logic [7:0]  p_out02,
  input  logic [7:0]  p_out03,
  input  logic [7:0]  p_out04,
  input  logic [7:0]  p_out05,
  input  logic [7:0]  p_out06,
  input  logic [7:0]  p_out07,
  output logic [7:0]  p_in08,
  output logic [7:0]  p_in09,
  output logic [7:0]  p_in10,
  output logic [7:0]  p_in11,
  output logic [7:0]  p_in12,
  output logic [7:0]  p_in13,
  output logic [7:0]  p_in14,
  output logic [7:0]  p_in15,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycles,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    SPARE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_start;
  logic        r_busy;
  logic        r_done;
  logic        r_timeout;
  logic [15:0] r_cycles;
  logic [7:0]  r_args [8];
  logic [7:0]  r_res  [8];

  logic [7:0]  w_pOut [8];
  logic [15:0] w_cyclesNext;
  logic        w_atLimit;
  logic        w_chainGo;

  assign w_pOut[0] = p_out00;
  assign w_pOut[1] = p_out01;
  assign w_pOut[2] = p_out02;
  assign w_pOut[3] = p_out03;
  assign w_pOut[4] = p_out04;
  assign w_pOut[5] = p_out05;
  assign w_pOut[6] = p_out06;
  assign w_pOut[7] = p_out07;

  assign w_cyclesNext = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;
  assign w_atLimit    = (r_cycles == 16'(TIMEOUT - 1));

`ifdef YASAC_RUNNER_CHAIN_EN
  assign w_chainGo = go & chain;
`else
  assign w_chainGo = 1'b0;
`endif

  // Outputs are loaded alongside the state they belong to, so p_start and busy are glitch-free Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cycles  <= '0;
      for (int i = 0; i < 8; i++) begin
        r_args[i] <= '0;
        r_res[i]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          if (w_chainGo) begin
            for (int i = 0; i < 8; i++) r_args[i] <= r_res[i];
          end else if (arg_we) begin
            r_args[arg_sel] <= arg_data;
          end
          if (go) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_cycles  <= '0;
            r_state   <= LAUNCH;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        LAUNCH: begin
          r_cycles <= w_cyclesNext;
          if (w_atLimit) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
          end else if (!p_ready) begin
            r_state <= RUN;
            r_start <= 1'b0;
          end
        end
        RUN: begin
          r_cycles <= w_cyclesNext;
          // Completion wins over timeout when both land on the same edge.
          if (p_ready) begin
            for (int i = 0; i < 8; i++) r_res[i] <= w_pOut[i];
            r_done  <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_atLimit) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    res_data = r_res[res_sel];
  end

  assign p_start   = r_start;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cycles    = r_cycles;
  assign state_out = r_state;

  assign p_in08 = r_args[0];
  assign p_in09 = r_args[1];
  assign p_in10 = r_args[2];
  assign p_in11 = r_args[3];
  assign p_in12 = r_args[4];
  assign p_in13 = r_args[5];
  assign p_in14 = r_args[6];
  assign p_in15 = r_args[7];

endmodule

// File: tb/tb_yasac_runner.sv
// Self-checking bench for yasac_runner: a cycle-scripted processor model drives p_ready,
// and a scoreboard of expected run outcomes is checked as each run finishes.
module tb_yasac_runner;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        arg_we;
  logic        chain;
  logic [2:0]  arg_sel;
  logic [7:0]  arg_data;
  logic [2:0]  res_sel;
  logic [7:0]  res_data;
  logic        p_start;
  logic        p_ready;
  logic [7:0]  pOut [8];
  logic [7:0]  p_in08, p_in09, p_in10, p_in11, p_in12, p_in13, p_in14, p_in15;
  logic        busy, done, timeout;
  logic [15:0] cycles;
  logic [1:0]  state_out;

  yasac_runner #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go), .arg_we(arg_we), .arg_sel(arg_sel), .arg_data(arg_data),
`ifdef YASAC_RUNNER_CHAIN_EN
    .chain(chain),
`endif
    .res_sel(res_sel), .res_data(res_data), .p_start(p_start), .p_ready(p_ready),
    .p_out00(pOut[0]), .p_out01(pOut[1]), .p_out02(pOut[2]), .p_out03(pOut[3]),
    .p_out04(pOut[4]), .p_out05(pOut[5]), .p_out06(pOut[6]), .p_out07(pOut[7]),
    .p_in08(p_in08), .p_in09(p_in09), .p_in10(p_in10), .p_in11(p_in11),
    .p_in12(p_in12), .p_in13(p_in13), .p_in14(p_in14), .p_in15(p_in15),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        tmo;
    logic [15:0] cycles;
    logic [7:0]  res0;
    logic [7:0]  res7;
  } exp_t;

  exp_t       sbQ [$];
  exp_t       obs;
  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] modelRes [8];
  logic [7:0] argModel [8];
  logic [7:0] obsFirstIn08, obsFirstIn15;
  logic       obsIn08Stable, obsDoneAtLaunch, obsTmoAtLaunch;
  bit         obsExpired;
  int         obsEdges;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Outcome model: the run completes on edge doneAt unless that lies past the timeout edge.
  task automatic expectRun(input int doneAt, input logic [7:0] base);
    exp_t e;
    if (doneAt <= TO) begin
      e.done = 1'b1; e.tmo = 1'b0; e.cycles = 16'(doneAt);
      e.res0 = base; e.res7 = base + 8'd7;
      for (int i = 0; i < 8; i++) modelRes[i] = base + 8'(i);
    end else begin
      e.done = 1'b0; e.tmo = 1'b1; e.cycles = 16'(TO);
      e.res0 = modelRes[0]; e.res7 = modelRes[7];
    end
    sbQ.push_back(e);
  endtask

  // Processor model: ready stays high before edge ackAt, low until edge doneAt, high from then on.
  task automatic doRun(input int ackAt, input int doneAt, input logic [7:0] base,
                       input bit useChain, input bit weWithGo, input bit midWrite);
    for (int i = 0; i < 8; i++) pOut[i] = base + 8'(i);
    go = 1'b1;
    chain = useChain;
    if (weWithGo) begin
      arg_we = 1'b1; arg_sel = 3'd0; arg_data = 8'hAA;
    end
    tick;
    go = 1'b0; chain = 1'b0; arg_we = 1'b0;
    obsFirstIn08 = p_in08;
    obsFirstIn15 = p_in15;
    obsDoneAtLaunch = done;
    obsTmoAtLaunch = timeout;
    obsIn08Stable = 1'b1;
    obsExpired = 1'b1;
    obsEdges = 0;
    for (int k = 1; k <= 200; k++) begin
      p_ready = (k < ackAt) || (k >= doneAt);
      if (midWrite && k == 5) begin
        arg_we = 1'b1; arg_sel = 3'd1; arg_data = 8'hFF; go = 1'b1;
      end
      tick;
      arg_we = 1'b0; go = 1'b0;
      if (p_in08 !== obsFirstIn08) obsIn08Stable = 1'b0;
      if (!busy) begin
        obsEdges = k;
        obsExpired = 1'b0;
        break;
      end
    end
    p_ready = 1'b1;
    obs.done = done;
    obs.tmo = timeout;
    obs.cycles = cycles;
    res_sel = 3'd0;
    #1 obs.res0 = res_data;
    res_sel = 3'd7;
    #1 obs.res7 = res_data;
  endtask

  task automatic test_reset;
    reset = 1'b0; go = 0; arg_we = 0; chain = 0; arg_sel = 0; arg_data = 0; res_sel = 0; p_ready = 1;
    for (int i = 0; i < 8; i++) begin pOut[i] = 8'h00; modelRes[i] = 8'h00; argModel[i] = 8'h00; end
    tick; tick;
    reset = 1'b1;
    tick;
    compared++; if (state_out !== 2'd0) begin $display("[TB] FAIL reset_state: got %0d want 0", state_out); mismatched++; end
    compared++; if (busy !== 1'b0 || p_start !== 1'b0) begin $display("[TB] FAIL reset_busy_start: got %b%b want 00", busy, p_start); mismatched++; end
    compared++; if (done !== 1'b0 || timeout !== 1'b0) begin $display("[TB] FAIL reset_flags: got %b%b want 00", done, timeout); mismatched++; end
    compared++; if (cycles !== 16'd0) begin $display("[TB] FAIL reset_cycles: got %0d want 0", cycles); mismatched++; end
    compared++; if (p_in08 !== 8'h00 || p_in15 !== 8'h00 || res_data !== 8'h00) begin $display("[TB] FAIL reset_regs: got %h %h %h want 00", p_in08, p_in15, res_data); mismatched++; end
    arg_we = 1; arg_sel = 0; arg_data = 8'h33;
    tick;
    arg_we = 0; go = 1;
    tick;
    go = 0;
    compared++; if (p_start !== 1'b1 || state_out !== 2'd1) begin $display("[TB] FAIL launch_entry: got start=%b state=%0d want 1/1", p_start, state_out); mismatched++; end
    tick;
    #2 reset = 1'b0;
    #1;
    compared++; if (p_start !== 1'b0) begin $display("[TB] FAIL async_start_drop: got %b want 0", p_start); mismatched++; end
    compared++; if (busy !== 1'b0 || cycles !== 16'd0 || state_out !== 2'd0) begin $display("[TB] FAIL async_reset: got busy=%b cycles=%0d state=%0d want 0/0/0", busy, cycles, state_out); mismatched++; end
    compared++; if (p_in08 !== 8'h00) begin $display("[TB] FAIL async_args: got %h want 00", p_in08); mismatched++; end
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_normal_run;
    exp_t e;
    arg_we = 1; arg_sel = 0; arg_data = 8'h2A;
    tick;
    arg_we = 0;
    argModel[0] = 8'h2A;
    expectRun(12, 8'h55);
    doRun(3, 12, 8'h55, 1'b0, 1'b0, 1'b0);
    e = sbQ.pop_front();
    compared++; if (obsExpired) begin $display("[TB] FAIL normal_budget: run never ended"); mismatched++; end
    compared++; if (obs.done !== e.done || obs.tmo !== e.tmo) begin $display("[TB] FAIL normal_flags: got %b%b want %b%b", obs.done, obs.tmo, e.done, e.tmo); mismatched++; end
    compared++; if (obs.cycles !== e.cycles || obsEdges != int'(e.cycles)) begin $display("[TB] FAIL normal_cycles: got %0d (edges %0d) want %0d", obs.cycles, obsEdges, e.cycles); mismatched++; end
    compared++; if (obs.res0 !== e.res0 || obs.res7 !== e.res7) begin $display("[TB] FAIL normal_results: got %h %h want %h %h", obs.res0, obs.res7, e.res0, e.res7); mismatched++; end
    compared++; if (obsFirstIn08 !== argModel[0] || !obsIn08Stable) begin $display("[TB] FAIL normal_args: got %h stable=%b want %h", obsFirstIn08, obsIn08Stable, argModel[0]); mismatched++; end
  endtask

  task automatic test_write_lockout;
    exp_t e;
    expectRun(9, 8'h60);
    doRun(3, 9, 8'h60, 1'b0, 1'b0, 1'b1);
    e = sbQ.pop_front();
    compared++; if (p_in09 !== argModel[1]) begin $display("[TB] FAIL lockout_write: got %h want %h", p_in09, argModel[1]); mismatched++; end
    compared++; if (obs.cycles !== e.cycles || obs.done !== e.done) begin $display("[TB] FAIL lockout_go_ignored: got cycles=%0d done=%b want %0d %b", obs.cycles, obs.done, e.cycles, e.done); mismatched++; end
    arg_we = 1; arg_sel = 1; arg_data = 8'hFF;
    tick;
    arg_we = 0;
    argModel[1] = 8'hFF;
    compared++; if (p_in09 !== argModel[1]) begin $display("[TB] FAIL idle_write: got %h want %h", p_in09, argModel[1]); mismatched++; end
  endtask

  task automatic test_timeout;
    exp_t e;
    expectRun(1000, 8'h90);
    doRun(3, 1000, 8'h90, 1'b0, 1'b0, 1'b0);
    e = sbQ.pop_front();
    compared++; if (obsExpired) begin $display("[TB] FAIL timeout_budget: run never ended"); mismatched++; end
    compared++; if (obs.tmo !== e.tmo || obs.done !== e.done || busy !== 1'b0) begin $display("[TB] FAIL timeout_flags: got tmo=%b done=%b busy=%b want %b %b 0", obs.tmo, obs.done, busy, e.tmo, e.done); mismatched++; end
    compared++; if (obs.cycles !== e.cycles) begin $display("[TB] FAIL timeout_cycles: got %0d want %0d", obs.cycles, e.cycles); mismatched++; end
    compared++; if (obs.res0 !== e.res0 || obs.res7 !== e.res7) begin $display("[TB] FAIL timeout_results_kept: got %h %h want %h %h", obs.res0, obs.res7, e.res0, e.res7); mismatched++; end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    expectRun(5, 8'h10);
    doRun(2, 5, 8'h10, 1'b0, 1'b1, 1'b0);
    argModel[0] = 8'hAA;
    e = sbQ.pop_front();
    compared++; if (obsDoneAtLaunch !== 1'b0 || obsTmoAtLaunch !== 1'b0) begin $display("[TB] FAIL b2b_flags_cleared: got done=%b tmo=%b want 0 0", obsDoneAtLaunch, obsTmoAtLaunch); mismatched++; end
    compared++; if (obsFirstIn08 !== argModel[0]) begin $display("[TB] FAIL b2b_write_with_go: got %h want %h", obsFirstIn08, argModel[0]); mismatched++; end
    compared++; if (obs.cycles !== e.cycles || obs.res0 !== e.res0) begin $display("[TB] FAIL b2b_first: got %0d %h want %0d %h", obs.cycles, obs.res0, e.cycles, e.res0); mismatched++; end
    expectRun(4, 8'h20);
    doRun(2, 4, 8'h20, 1'b0, 1'b0, 1'b0);
    e = sbQ.pop_front();
    compared++; if (obsDoneAtLaunch !== 1'b0) begin $display("[TB] FAIL b2b_done_cleared: got %b want 0", obsDoneAtLaunch); mismatched++; end
    compared++; if (obs.cycles !== e.cycles || obs.done !== e.done || obs.res7 !== e.res7) begin $display("[TB] FAIL b2b_second: got %0d %b %h want %0d %b %h", obs.cycles, obs.done, obs.res7, e.cycles, e.done, e.res7); mismatched++; end
  endtask

  task automatic test_simultaneous;
    exp_t e;
    expectRun(TO, 8'hC0);
    doRun(3, TO, 8'hC0, 1'b0, 1'b0, 1'b0);
    e = sbQ.pop_front();
    compared++; if (obs.done !== e.done || obs.tmo !== e.tmo) begin $display("[TB] FAIL simul_flags: got done=%b tmo=%b want %b %b", obs.done, obs.tmo, e.done, e.tmo); mismatched++; end
    compared++; if (obs.cycles !== e.cycles) begin $display("[TB] FAIL simul_cycles: got %0d want %0d", obs.cycles, e.cycles); mismatched++; end
    compared++; if (obs.res0 !== e.res0 || obs.res7 !== e.res7) begin $display("[TB] FAIL simul_results: got %h %h want %h %h", obs.res0, obs.res7, e.res0, e.res7); mismatched++; end
  endtask

`ifdef YASAC_RUNNER_CHAIN_EN
  task automatic test_chain;
    exp_t e;
    logic [7:0] want08, want15;
    expectRun(6, 8'h07);
    doRun(3, 6, 8'h07, 1'b0, 1'b0, 1'b0);
    e = sbQ.pop_front();
    compared++; if (obs.res0 !== e.res0) begin $display("[TB] FAIL chain_seed: got %h want %h", obs.res0, e.res0); mismatched++; end
    want08 = modelRes[0];
    want15 = modelRes[7];
    expectRun(7, 8'h40);
    doRun(3, 7, 8'h40, 1'b1, 1'b1, 1'b0);
    e = sbQ.pop_front();
    compared++; if (obsFirstIn08 !== want08 || obsFirstIn15 !== want15) begin $display("[TB] FAIL chain_copy: got %h %h want %h %h", obsFirstIn08, obsFirstIn15, want08, want15); mismatched++; end
    compared++; if (obs.res0 !== e.res0 || obs.cycles !== e.cycles) begin $display("[TB] FAIL chain_run: got %h %0d want %h %0d", obs.res0, obs.cycles, e.res0, e.cycles); mismatched++; end
  endtask
`endif

  initial begin
    test_reset;
    test_normal_run;
    test_write_lockout;
    test_timeout;
    test_back_to_back;
    test_simultaneous;
`ifdef YASAC_RUNNER_CHAIN_EN
    test_chain;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
